grf_2r1w: RTL and testbench
===========================

GRF_2R1W -- requirements
Module: grf_2r1w

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter REG_NUM, default 32, number of architectural registers; address width log2(REG_NUM) = 5.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port we, input, 1, write enable from write-back stage.
REQ-006 The block SHALL have port a3, input, 5, write address, driven by the destination-register select mux (rt / rd / $31).
REQ-007 The block SHALL have port wd, input, DATA_W, write data.
REQ-008 The block SHALL have ports a1 and a2, input, 5 each, read addresses (rs, rt).
REQ-009 The block SHALL have ports rd1 and rd2, output, DATA_W each, read data.
REQ-010 The block SHALL have port wb_valid, output, 1, registered trace strobe for a committed write.
REQ-011 The block SHALL have ports wb_addr, output, 5, and wb_data, output, DATA_W, registered trace of the committed write.
REQ-012 The block SHALL have port wr_count, output, 32, count of committed writes since reset.

Function
REQ-013 Register array SHALL be REG_NUM x DATA_W; register 0 SHALL read as zero at all times.
REQ-014 On rising clk with we=1 and a3!=0, reg[a3] SHALL take wd; a3=0 SHALL leave all registers unchanged.
REQ-015 Reads SHALL be combinational: rdN = (aN==0) ? 0 : reg[aN], zero-latency.
REQ-016 Internal bypass: when we=1, a3!=0 and aN==a3 in the same cycle, rdN SHALL equal wd, not the stale array value.
REQ-017 Bypass SHALL apply independently to both ports; a1==a2==a3 SHALL return wd on both.
REQ-018 A committed write (we=1, a3!=0) SHALL, one cycle later, present wb_valid=1, wb_addr=a3, wb_data=wd for exactly one cycle per write.
REQ-019 we=1 with a3=0 SHALL NOT assert wb_valid and SHALL NOT increment wr_count.
REQ-020 wr_count SHALL increment by 1 on each committed write, wrapping 0xFFFFFFFF -> 0.
REQ-021 Back-to-back writes to the same address SHALL each commit; the later write SHALL win for subsequent reads.
REQ-022 X on a3 or wd with we=0 SHALL NOT change state.

Reset
REQ-023 reset_n=0 SHALL immediately, independent of clk, clear all registers to 0, wb_valid to 0, wb_addr to 0, wb_data to 0 and wr_count to 0.
REQ-024 While reset_n=0, writes SHALL be ignored; rdN SHALL read 0 for every address.
REQ-025 Reset deassertion SHALL be synchronised externally; the first write takes effect on the first rising edge with reset_n=1.

Structure
REQ-026 A shared package SHALL hold DATA_W, REG_NUM, ADDR_W=5, REG_ZERO=0 and REG_RA=31 (link register used by the destination select).
REQ-027 The block SHALL instantiate one sub-module, grf_read_port, twice; each instance implements the zero-check and bypass for one read port.
REQ-028 No other sub-modules; trace registers and counter SHALL be local to grf_2r1w.

Verification
REQ-029 Reset, then we=1,a3=5,wd=0x1234 at one edge; next cycle a1=5 -> rd1=0x1234, wb_valid=1, wb_addr=5, wb_data=0x1234, wr_count=1.
REQ-030 we=1,a3=0,wd=0xFFFFFFFF; a1=0 -> rd1=0 before and after the edge, wb_valid=0, wr_count unchanged.
REQ-031 reg[8]=0xAAAA; same cycle we=1,a3=8,wd=0x5555 with a1=a2=8 -> rd1=rd2=0x5555 before the edge.
REQ-032 we=1,a3=31,wd=0x00400008 (jal link); then a2=31 -> rd2=0x00400008.
REQ-033 Write reg[3]=7, then assert reset_n=0 mid-cycle -> rd for a1=3 is 0 immediately, wr_count=0, wb_valid=0.
REQ-034 Preload wr_count to 0xFFFFFFFF via writes (or force), one more committed write -> wr_count=0.

Source files
------------

// File: rtl/grf_2r1w_pkg.sv
// grf_2r1w_pkg: shared sizing constants and helpers for the 2-read/1-write register file.
package grf_2r1w_pkg;
   localparam int DATA_W = 32;
   localparam int REG_NUM = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;
   localparam logic [ADDR_W-1:0] REG_RA = 5'd31;

   function automatic logic is_commit(input logic we, input logic [ADDR_W-1:0] a3);
      return we && (a3 != REG_ZERO);
   endfunction
endpackage

// File: rtl/grf_read_port.sv
// grf_read_port: one combinational read port with hardwired-zero register and write bypass.
module grf_read_port
   import grf_2r1w_pkg::*;
#(
   parameter int DATA_W = grf_2r1w_pkg::DATA_W
) (
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] arr_data,
   input  logic              byp_en,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd
);
   always_comb begin
      rd = (a == REG_ZERO) ? '0 : (byp_en && (a == wa)) ? wd : arr_data;
   end
endmodule

// File: rtl/grf_2r1w.sv
// grf_2r1w: general register file, two combinational read ports with bypass, one write port,
// plus a registered write-back trace and committed-write counter.
module grf_2r1w
   import grf_2r1w_pkg::*;
#(
   parameter int DATA_W = grf_2r1w_pkg::DATA_W,
   parameter int REG_NUM = grf_2r1w_pkg::REG_NUM
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] a3,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] a1,
   input  logic [ADDR_W-1:0] a2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       wr_count
);
   logic              commit;
   logic              byp_en;
   logic [DATA_W-1:0] regs_q [REG_NUM];
   logic [DATA_W-1:0] regs_d [REG_NUM];
   logic              wb_valid_q, wb_valid_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [31:0]       wr_count_q, wr_count_d;

   always_comb begin
      commit = is_commit(we, a3);
      regs_d = regs_q;
      if (commit) regs_d[a3] = wd;
      wb_valid_d = commit;
      wb_addr_d = commit ? a3 : wb_addr_q;
      wb_data_d = commit ? wd : wb_data_q;
      wr_count_d = wr_count_q + {31'd0, commit};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q <= '{default: '0};
         wb_valid_q <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wr_count_q <= '0;
      end else begin
         regs_q <= regs_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Bypass is suppressed in reset so every read returns zero while reset_n is low.
   assign byp_en = commit & reset_n;

   grf_read_port #(.DATA_W(DATA_W)) u_rp1 (
      .a(a1), .arr_data(regs_q[a1]), .byp_en(byp_en), .wa(a3), .wd(wd), .rd(rd1)
   );

   grf_read_port #(.DATA_W(DATA_W)) u_rp2 (
      .a(a2), .arr_data(regs_q[a2]), .byp_en(byp_en), .wa(a3), .wd(wd), .rd(rd2)
   );

   assign wb_valid = wb_valid_q;
   assign wb_addr = wb_addr_q;
   assign wb_data = wb_data_q;
   assign wr_count = wr_count_q;
endmodule

// File: tb/tb_grf_2r1w.sv
// tb_grf_2r1w: scoreboard bench for grf_2r1w; write-back trace checked against a queue of committed writes.
module tb_grf_2r1w;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  a3 = '0, a1 = '0, a2 = '0;
   logic [31:0] wd = '0;
   logic [31:0] rd1, rd2, wb_data, wr_count;
   logic        wb_valid;
   logic [4:0]  wb_addr;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_regs [32];
   logic [31:0] exp_cnt = '0;
   logic [36:0] sb_q [$];

   grf_2r1w dut (
      .clk(clk), .reset_n(reset_n), .we(we), .a3(a3), .wd(wd), .a1(a1), .a2(a2),
      .rd1(rd1), .rd2(rd2), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mrd(input logic [4:0] a);
      if (!reset_n || a == 5'd0) return 32'd0;
      if (we && a3 != 5'd0 && a == a3) return wd;
      return exp_regs[a];
   endfunction

   always @(posedge clk) begin
      if (reset_n && we && a3 != 5'd0) begin
         sb_q.push_back({a3, wd});
         exp_regs[a3] = wd;
         exp_cnt = exp_cnt + 32'd1;
      end
   end

   always @(negedge clk) begin
      logic [36:0] e;
      if (wb_valid) begin
         if (sb_q.size() == 0) check("wb_spurious", {31'd0, wb_valid}, 32'd0);
         else begin
            e = sb_q.pop_front();
            check("wb_addr", {27'd0, wb_addr}, {27'd0, e[36:32]});
            check("wb_data", wb_data, e[31:0]);
         end
      end else if (sb_q.size() != 0) begin
         check("wb_missing", {31'd0, wb_valid}, 32'd1);
         sb_q.delete();
      end
      check("wr_count", wr_count, exp_cnt);
   end

   task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] d,
                      input logic [4:0] r1, input logic [4:0] r2);
      @(negedge clk);
      #1;
      we = w; a3 = wa; wd = d; a1 = r1; a2 = r2;
      #1;
      check("rd1", rd1, mrd(r1));
      check("rd2", rd2, mrd(r2));
   endtask

   task automatic model_reset();
      foreach (exp_regs[i]) exp_regs[i] = '0;
      exp_cnt = '0;
      sb_q.delete();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      a1 = 5'd5;
      #1;
      check("rst_rd1", rd1, 32'd0);
      check("rst_wbv", {31'd0, wb_valid}, 32'd0);
      check("rst_cnt", wr_count, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      // first write and its trace
      cyc(1, 5, 32'h1234, 0, 0);
      cyc(0, 0, 0, 5, 0);
      check("w1_rd1", rd1, 32'h1234);
      check("w1_wbv", {31'd0, wb_valid}, 32'd1);
      check("w1_wba", {27'd0, wb_addr}, 32'd5);
      check("w1_wbd", wb_data, 32'h1234);
      check("w1_cnt", wr_count, 32'd1);
      // write to r0 is dropped
      cyc(1, 0, 32'hFFFF_FFFF, 0, 0);
      check("r0_rd1", rd1, 32'd0);
      cyc(0, 0, 0, 0, 0);
      check("r0_rd1b", rd1, 32'd0);
      check("r0_wbv", {31'd0, wb_valid}, 32'd0);
      check("r0_cnt", wr_count, 32'd1);
      // same-cycle bypass on both ports, back-to-back writes
      cyc(1, 8, 32'hAAAA, 0, 0);
      cyc(1, 8, 32'h5555, 8, 8);
      check("byp_rd1", rd1, 32'h5555);
      check("byp_rd2", rd2, 32'h5555);
      cyc(0, 0, 0, 8, 8);
      check("b2b_rd1", rd1, 32'h5555);
      check("b2b_cnt", wr_count, 32'd3);
      // link register
      cyc(1, 31, 32'h0040_0008, 0, 0);
      cyc(0, 0, 0, 0, 31);
      check("ra_rd2", rd2, 32'h0040_0008);
      for (int i = 0; i < 60; i++)
         cyc(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      // async reset mid-cycle
      cyc(1, 3, 32'd7, 0, 0);
      cyc(0, 0, 0, 3, 3);
      check("r3_rd1", rd1, 32'd7);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("arst_rd1", rd1, 32'd0);
      check("arst_cnt", wr_count, 32'd0);
      check("arst_wbv", {31'd0, wb_valid}, 32'd0);
      cyc(1, 3, 32'd9, 3, 3);
      check("inrst_rd1", rd1, 32'd0);
      cyc(0, 0, 0, 3, 0);
      check("inrst_rd1b", rd1, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(0, 0, 0, 3, 0);
      check("post_rst_rd1", rd1, 32'd0);
      // counter wrap
      @(negedge clk);
      #1;
      force dut.wr_count_q = 32'hFFFF_FFFF;
      exp_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.wr_count_q;
      cyc(0, 0, 0, 0, 0);
      cyc(1, 4, 32'h44, 0, 0);
      cyc(0, 0, 0, 4, 0);
      check("wrap_cnt", wr_count, 32'd0);
      cyc(0, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
